// File: rtl/coin_accumulator.sv
// Coin decode and credit accumulation ahead of vending_machine.
// Credit clears on success or refund, then coins are locked out briefly.
module coin_accumulator #(
    parameter logic [15:0] MAX_CREDIT  = 16'd1000,
    parameter int          LOCK_CYCLES = 4
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_COIN_VALID,
    input  logic [2:0]  I_COIN_CODE,
    input  logic        I_REFUND,
    input  logic        I_SUCCESS,
    output logic [15:0] O_CREDIT,
    output logic        O_REJECT,
    output logic        O_REFUND_VALID,
    output logic [15:0] O_REFUND_AMT,
    output logic        O_BUSY
);

    localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CW-1:0] LOCK_INIT = CW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_LOCK  = 3'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   credit_d;
    logic [15:0]   ramt_d;
    logic          reject_d;
    logic          rvalid_d;
    logic          refund_q;
    logic          refund_edge;
    logic          coin_ok;
    logic [15:0]   coin_val;
    logic [16:0]   sum;
    logic          fits;

    always_comb begin
        coin_ok  = 1'b1;
        coin_val = 16'd0;
        case (I_COIN_CODE)
            3'd0:    coin_val = 16'd1;
            3'd1:    coin_val = 16'd5;
            3'd2:    coin_val = 16'd10;
            3'd3:    coin_val = 16'd25;
            3'd4:    coin_val = 16'd100;
            3'd5:    coin_val = 16'd500;
            default: coin_ok  = 1'b0;
        endcase
    end

    // 17-bit sum so an over-limit coin can never wrap into range
    assign sum         = {1'b0, O_CREDIT} + {1'b0, coin_val};
    assign fits        = coin_ok && (sum <= {1'b0, MAX_CREDIT});
    assign refund_edge = I_REFUND & ~refund_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        credit_d = O_CREDIT;
        ramt_d   = O_REFUND_AMT;
        reject_d = 1'b0;
        rvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_COIN_VALID) begin
                    if (fits) begin
                        credit_d = sum[15:0];
                        state_d  = S_ACCUM;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                if (I_SUCCESS) begin
                    credit_d = 16'd0;
                    cnt_d    = LOCK_INIT;
                    state_d  = S_LOCK;
                    reject_d = I_COIN_VALID;
                end else if (refund_edge) begin
                    ramt_d   = O_CREDIT;
                    rvalid_d = 1'b1;
                    credit_d = 16'd0;
                    cnt_d    = LOCK_INIT;
                    state_d  = S_LOCK;
                    reject_d = I_COIN_VALID;
                end else if (I_COIN_VALID) begin
                    if (fits) credit_d = sum[15:0];
                    else      reject_d = 1'b1;
                end
            end
            S_LOCK: begin
                reject_d = I_COIN_VALID;
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            refund_q       <= 1'b0;
            O_CREDIT       <= 16'd0;
            O_REJECT       <= 1'b0;
            O_REFUND_VALID <= 1'b0;
            O_REFUND_AMT   <= 16'd0;
            O_BUSY         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            refund_q       <= I_REFUND;
            O_CREDIT       <= credit_d;
            O_REJECT       <= reject_d;
            O_REFUND_VALID <= rvalid_d;
            O_REFUND_AMT   <= ramt_d;
            O_BUSY         <= (state_d == S_LOCK);
        end
    end

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator.
// Inputs change and outputs are sampled on the falling edge.
module tb_coin_accumulator;

    logic        clk;
    logic        rst;
    logic        coin_valid;
    logic [2:0]  coin_code;
    logic        refund;
    logic        success;
    logic [15:0] credit;
    logic        reject;
    logic        refund_valid;
    logic [15:0] refund_amt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    coin_accumulator dut (
        .I_CLK          (clk),
        .I_RESET        (rst),
        .I_COIN_VALID   (coin_valid),
        .I_COIN_CODE    (coin_code),
        .I_REFUND       (refund),
        .I_SUCCESS      (success),
        .O_CREDIT       (credit),
        .O_REJECT       (reject),
        .O_REFUND_VALID (refund_valid),
        .O_REFUND_AMT   (refund_amt),
        .O_BUSY         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic coin(input logic [2:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 10) begin
            step();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst        = 1'b1;
        coin_valid = 1'b0;
        coin_code  = 3'd0;
        refund     = 1'b0;
        success    = 1'b0;
        step();
        check("rst_credit", {16'd0, credit}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_amt", {16'd0, refund_amt}, 32'd0);
        rst = 1'b0;
        step();

        // T1
        coin(3'd4);
        check("t1_c100", {16'd0, credit}, 32'd100);
        coin(3'd3);
        check("t1_c125", {16'd0, credit}, 32'd125);
        coin(3'd3);
        check("t1_c150", {16'd0, credit}, 32'd150);
        success = 1'b1;
        step();
        success = 1'b0;
        check("t1_clear", {16'd0, credit}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_busy%0d", i), {31'd0, busy}, 32'd1);
            step();
        end
        check("t1_idle", {31'd0, busy}, 32'd0);

        // T2
        coin(3'd5);
        coin(3'd4);
        coin(3'd4);
        coin(3'd4);
        coin(3'd4);
        check("t2_c900", {16'd0, credit}, 32'd900);
        coin(3'd5);
        check("t2_rej", {31'd0, reject}, 32'd1);
        check("t2_hold", {16'd0, credit}, 32'd900);
        step();
        check("t2_rej_pulse", {31'd0, reject}, 32'd0);
        coin(3'd4);
        check("t2_limit", {16'd0, credit}, 32'd1000);
        check("t2_lim_norej", {31'd0, reject}, 32'd0);
        coin(3'd0);
        check("t2_over1", {31'd0, reject}, 32'd1);
        check("t2_hold1000", {16'd0, credit}, 32'd1000);
        success = 1'b1;
        step();
        success = 1'b0;
        wait_idle("t2_unlock");

        // T3
        coin(3'd4);
        coin(3'd4);
        coin(3'd3);
        coin(3'd3);
        check("t3_c250", {16'd0, credit}, 32'd250);
        refund = 1'b1;
        step();
        check("t3_rvalid", {31'd0, refund_valid}, 32'd1);
        check("t3_amt", {16'd0, refund_amt}, 32'd250);
        check("t3_clear", {16'd0, credit}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (refund_valid) pulses++;
        end
        check("t3_single", pulses, 32'd0);
        refund = 1'b0;
        wait_idle("t3_unlock");

        // T4
        coin(3'd4);
        coin(3'd3);
        coin(3'd3);
        check("t4_c150", {16'd0, credit}, 32'd150);
        success    = 1'b1;
        refund     = 1'b1;
        coin_valid = 1'b1;
        coin_code  = 3'd1;
        step();
        success    = 1'b0;
        refund     = 1'b0;
        coin_valid = 1'b0;
        check("t4_clear", {16'd0, credit}, 32'd0);
        check("t4_norv", {31'd0, refund_valid}, 32'd0);
        check("t4_rej", {31'd0, reject}, 32'd1);
        check("t4_amt", {16'd0, refund_amt}, 32'd250);
        wait_idle("t4_unlock");

        // T5
        coin(3'd4);
        success = 1'b1;
        step();
        success = 1'b0;
        step();
        coin(3'd2);
        check("t5_lock_rej", {31'd0, reject}, 32'd1);
        check("t5_lock_cr", {16'd0, credit}, 32'd0);
        wait_idle("t5_unlock");
        coin(3'd7);
        check("t5_inv_rej", {31'd0, reject}, 32'd1);
        check("t5_inv_cr", {16'd0, credit}, 32'd0);
        coin(3'd2);
        check("t5_accept", {16'd0, credit}, 32'd10);
        check("t5_acc_norej", {31'd0, reject}, 32'd0);
        refund = 1'b1;
        step();
        refund = 1'b0;
        check("t5_ramt", {16'd0, refund_amt}, 32'd10);
        wait_idle("t5_unlock2");

        // T6
        coin(3'd4);
        coin(3'd4);
        coin(3'd4);
        check("t6_c300", {16'd0, credit}, 32'd300);
        #2;
        rst = 1'b1;
        #1;
        check("t6_credit", {16'd0, credit}, 32'd0);
        check("t6_rv", {31'd0, refund_valid}, 32'd0);
        check("t6_amt", {16'd0, refund_amt}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_rej", {31'd0, reject}, 32'd0);
        coin(3'd5);
        check("t6_rst_coin", {16'd0, credit}, 32'd0);
        rst = 1'b0;
        step();
        coin(3'd0);
        check("t6_idle_coin", {16'd0, credit}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
